// File: rtl/microwave_countdown_if.sv
// Keypad/control inputs and BCD display/status outputs of the microwave countdown controller.
interface microwave_countdown_if;
  logic       tick_1hz;
  logic       digit_valid;
  logic [3:0] digit;
  logic       start;
  logic       stop;
  logic       door_open;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       magnetron_on;
  logic       done;
  logic [2:0] state;

  modport master (
    output tick_1hz, digit_valid, digit, start, stop, door_open,
    input  min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done, state
  );

  modport slave (
    input  tick_1hz, digit_valid, digit, start, stop, door_open,
    output min_tens, min_ones, sec_tens, sec_ones, magnetron_on, done, state
  );
endinterface

// File: rtl/microwave_countdown.sv
// Microwave cook-time entry (MM:SS BCD) and one-second countdown with pause/door interlock.
// Latency: one clk edge from sampled strobe to outputs; no backpressure, every strobe is acted on or dropped.
module microwave_countdown (
  input  logic                  clk,
  input  logic                  reset,
  microwave_countdown_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q;
  logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
  logic       digit_ok;
  logic       time_zero;
  logic       dec_zero;

  assign digit_ok  = bus.digit_valid && (bus.digit <= 4'd9);
  assign time_zero = ({min_tens_q, min_ones_q, sec_tens_q, sec_ones_q} == 16'd0);
  assign dec_zero  = ({dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones} == 16'd0);

  // Seconds borrow from 0 to 5 (not 9) so entered 60-99 values still count down unchanged.
  always_comb begin
    dec_min_tens = min_tens_q;
    dec_min_ones = min_ones_q;
    dec_sec_tens = sec_tens_q;
    dec_sec_ones = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_sec_ones = sec_ones_q - 4'd1;
    end else begin
      dec_sec_ones = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_sec_tens = sec_tens_q - 4'd1;
      end else begin
        dec_sec_tens = 4'd5;
        if (min_ones_q != 4'd0) begin
          dec_min_ones = min_ones_q - 4'd1;
        end else begin
          dec_min_ones = 4'd9;
          dec_min_tens = min_tens_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          // In IDLE the digits are zero, so a stop there is a no-op and start never applies.
          if (bus.stop && state_q == ENTRY) begin
            state_q    <= IDLE;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
          end else if (bus.start && !bus.door_open && !time_zero && state_q == ENTRY) begin
            state_q <= COOK;
          end else if (digit_ok) begin
            state_q    <= ENTRY;
            min_tens_q <= min_ones_q;
            min_ones_q <= sec_tens_q;
            sec_tens_q <= sec_ones_q;
            sec_ones_q <= bus.digit;
          end
        end
        COOK: begin
          if (bus.stop || bus.door_open) begin
            state_q <= PAUSE;
          end else if (bus.tick_1hz) begin
            min_tens_q <= dec_min_tens;
            min_ones_q <= dec_min_ones;
            sec_tens_q <= dec_sec_tens;
            sec_ones_q <= dec_sec_ones;
            if (dec_zero) state_q <= DONE;
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state_q    <= IDLE;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
          end else if (bus.start && !bus.door_open) begin
            state_q <= COOK;
          end
        end
        DONE: begin
          if (bus.stop) begin
            state_q    <= IDLE;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
          end else if (digit_ok) begin
            state_q    <= ENTRY;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= bus.digit;
          end
        end
        default: begin
          state_q    <= IDLE;
          min_tens_q <= 4'd0;
          min_ones_q <= 4'd0;
          sec_tens_q <= 4'd0;
          sec_ones_q <= 4'd0;
        end
      endcase
    end
  end

  assign bus.min_tens     = min_tens_q;
  assign bus.min_ones     = min_ones_q;
  assign bus.sec_tens     = sec_tens_q;
  assign bus.sec_ones     = sec_ones_q;
  assign bus.state        = state_q;
  assign bus.magnetron_on = (state_q == COOK);
  assign bus.done         = (state_q == DONE);
endmodule

// File: tb/tb_microwave_countdown.sv
// Directed bench for microwave_countdown; expected displays are hand-computed BCD MM:SS values.
module tb_microwave_countdown;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  microwave_countdown_if bus ();

  microwave_countdown dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] S_IDLE = 3'd0, S_ENTRY = 3'd1, S_COOK = 3'd2, S_PAUSE = 3'd3, S_DONE = 3'd4;

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] disp();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic key(input logic [3:0] d);
    bus.digit = d; bus.digit_valid = 1'b1; step(); bus.digit_valid = 1'b0;
  endtask

  task automatic press_start();
    bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  task automatic press_stop();
    bus.stop = 1'b1; step(); bus.stop = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1hz = 1'b1; step(); bus.tick_1hz = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    bus.tick_1hz = 1'b0; bus.digit_valid = 1'b0; bus.digit = 4'd0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.door_open = 1'b0;
    #1;
    step(); step();
    reset = 1'b0;
    chk("reset_state", {13'd0, bus.state}, {13'd0, S_IDLE});
    chk("reset_disp", disp(), 16'h0000);
    chk("reset_mag_done", {14'd0, bus.magnetron_on, bus.done}, 16'd0);

    // 01:30 cook-out
    key(4'd1); key(4'd3); key(4'd0);
    chk("load_0130", disp(), 16'h0130);
    chk("load_state", {13'd0, bus.state}, {13'd0, S_ENTRY});
    press_start();
    chk("start_cook", {13'd0, bus.state}, {13'd0, S_COOK});
    chk("start_mag", {15'd0, bus.magnetron_on}, 16'd1);
    ticks(1);
    chk("tick1_0129", disp(), 16'h0129);
    ticks(30);
    chk("tick31_0059", disp(), 16'h0059);
    ticks(58);
    chk("tick89_0001", disp(), 16'h0001);
    ticks(1);
    chk("tick90_0000", disp(), 16'h0000);
    chk("tick90_state", {13'd0, bus.state}, {13'd0, S_DONE});
    chk("tick90_mag_done", {14'd0, bus.magnetron_on, bus.done}, 16'd1);
    press_start();
    chk("done_start_ign", {13'd0, bus.state}, {13'd0, S_DONE});

    // Long entry from DONE, then minute borrow
    key(4'd1);
    chk("done_digit", disp(), 16'h0001);
    chk("done_digit_state", {13'd0, bus.state}, {13'd0, S_ENTRY});
    key(4'd0); key(4'd0); key(4'd0);
    chk("entry_1000", disp(), 16'h1000);
    key(4'd5);
    chk("fifth_digit", disp(), 16'h0005);
    press_stop();
    chk("entry_clear", disp(), 16'h0000);
    chk("entry_clear_state", {13'd0, bus.state}, {13'd0, S_IDLE});
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    press_start();
    ticks(1);
    chk("borrow_0959", disp(), 16'h0959);

    // Door/stop interlock at 00:10
    press_stop(); press_stop();
    key(4'd1); key(4'd0);
    press_start();
    chk("cook_0010", disp(), 16'h0010);
    bus.door_open = 1'b1; bus.tick_1hz = 1'b1; step(); bus.tick_1hz = 1'b0;
    chk("door_pause", {13'd0, bus.state}, {13'd0, S_PAUSE});
    chk("door_hold", disp(), 16'h0010);
    chk("door_mag", {15'd0, bus.magnetron_on}, 16'd0);
    press_start();
    chk("door_start_ign", {13'd0, bus.state}, {13'd0, S_PAUSE});
    bus.door_open = 1'b0;
    press_start();
    chk("resume_cook", {13'd0, bus.state}, {13'd0, S_COOK});
    press_stop();
    chk("stop_pause", {13'd0, bus.state}, {13'd0, S_PAUSE});
    press_stop();
    chk("stop_idle", {13'd0, bus.state}, {13'd0, S_IDLE});
    chk("stop_clear", disp(), 16'h0000);

    // Input rejection
    key(4'd12);
    chk("bad_digit_disp", disp(), 16'h0000);
    chk("bad_digit_state", {13'd0, bus.state}, {13'd0, S_IDLE});
    press_start();
    chk("idle_start_ign", {13'd0, bus.state}, {13'd0, S_IDLE});
    key(4'd1); key(4'd2);
    press_start();
    key(4'd7);
    chk("cook_digit_ign", disp(), 16'h0012);
    chk("cook_digit_state", {13'd0, bus.state}, {13'd0, S_COOK});

    // Seconds above 59
    press_stop(); press_stop();
    key(4'd9); key(4'd0);
    press_start();
    ticks(1);
    chk("sec90_0089", disp(), 16'h0089);

    // Reset mid-cook at 03:15
    press_stop(); press_stop();
    key(4'd3); key(4'd1); key(4'd5);
    press_start();
    chk("pre_reset_cook", {13'd0, bus.state}, {13'd0, S_COOK});
    reset = 1'b1; bus.tick_1hz = 1'b1; bus.start = 1'b1;
    step();
    reset = 1'b0; bus.tick_1hz = 1'b0; bus.start = 1'b0;
    chk("midreset_state", {13'd0, bus.state}, {13'd0, S_IDLE});
    chk("midreset_disp", disp(), 16'h0000);
    chk("midreset_mag_done", {14'd0, bus.magnetron_on, bus.done}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/microwave_countdown.md
# microwave_countdown

Microwave cook-time entry and countdown controller. Accepts keypad digits, holds cook time as four BCD digits (MM:SS), runs a one-second countdown while cooking, and handles pause, resume, door interlock and clear. It sits directly upstream of the four seven-segment decoders: each BCD output drives one decoder's x3..x0 inputs.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- tick_1hz  in  1  one-cycle enable pulse, once per second, synchronous to clk.
- digit_valid  in  1  one-cycle strobe; digit is valid this cycle.
- digit  in  4  keypad value; values 10-15 are ignored.
- start  in  1  one-cycle strobe: start or resume.
- stop  in  1  one-cycle strobe: pause, or clear when not cooking.
- door_open  in  1  level signal; 1 = door open.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits to the decoders.
- magnetron_on  out  1  high exactly while state = COOK.
- done  out  1  high while state = DONE.
- state  out  3  IDLE=0, ENTRY=1, COOK=2, PAUSE=3, DONE=4.

## Operation
- Reset: state=IDLE, all four digits=0, magnetron_on=0, done=0.
- Time is zero when all four digits are 0.
- Event priority in one cycle: reset > stop > door_open > start > digit_valid > tick_1hz. Only the highest-priority event that applies in the current state acts.
- IDLE:
  - Accepted digit (≤9): shift it in and go to ENTRY.
  - start: ignored, because time is zero.
  - stop: no effect.
- ENTRY:
  - Accepted digit: shift left. min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←digit. The old min_tens is discarded, so a fifth digit drops the oldest.
  - start with door_open=0 and nonzero time: go to COOK.
  - start with door_open=1 or zero time: ignored.
  - stop: clear all digits and go to IDLE.
- COOK:
  - tick_1hz: BCD decrement.
  - stop or door_open: go to PAUSE with digits held, and no decrement that cycle.
  - digit_valid and start: ignored.
- PAUSE:
  - start with door_open=0: go to COOK.
  - stop: clear and go to IDLE.
  - digit_valid and tick_1hz: ignored.
- DONE:
  - Digits read 00:00.
  - stop: go to IDLE.
  - Accepted digit: digits become 000d and state goes to ENTRY.
  - start: ignored.
- BCD decrement:
  - If sec_ones>0, decrement sec_ones.
  - Otherwise sec_ones=9, and:
    - If sec_tens>0, decrement sec_tens.
    - Otherwise sec_tens=5 and minutes decrement: min_ones-1, or min_ones=9 with min_tens-1.
  - If the decremented value is zero, state goes to DONE on the same edge.
- Entered seconds of 60-99 are legal and count down as-is (00:90 → 00:89 … 00:00). No normalisation.
- Digits never leave 0-9. min_tens never underflows, because zero time always exits COOK.

## Timing
- All state and digits are registered and update on the rising clk edge where the triggering input is sampled high. Outputs are visible the following cycle.
- magnetron_on and done are decoded from the state register only, with no extra latency.
- A tick_1hz in the same cycle as the start that enters COOK is not counted. The first decrement is on the first tick sampled while state=COOK.
- Final tick from 00:01: digits become 00:00, state=DONE, and magnetron_on=0, all on the same edge.
- An N-second cook (N ≤ 59) therefore takes exactly N ticks after entering COOK.
- Reset mid-operation: the next edge forces reset values regardless of the other inputs.

## Test plan
- Load 01:30 and cook it out: reset, digits 1,3,0, start with the door closed, then 90 ticks. Required: display 01:30 before start, 01:29 after tick 1, 00:59 after tick 31, and 00:00 with done=1 and magnetron_on=0 after tick 90.
- Minute borrow and long entry: enter 1,0,0,0 then a fifth digit 5, giving 00:05. Clear with stop, enter 1,0,0,0, start, one tick. Required: 09:59.
- Door and stop interlock:
  - During COOK at 00:10, assert door_open in the same cycle as a tick. Required: PAUSE, digits stay 00:10, magnetron_on=0.
  - Start while door_open=1. Required: stays in PAUSE.
  - Close the door and start. Required: COOK.
  - stop once. Required: PAUSE.
  - stop again. Required: IDLE with 00:00.
- Input rejection:
  - digit=12 with digit_valid. Required: no change.
  - start in IDLE. Required: stays IDLE.
  - digit_valid during COOK. Required: digits unchanged.
- Seconds above 59: enter 9,0 (00:90), start, one tick. Required: 00:89.
- Reset mid-cook: assert reset during COOK at 03:15. Required: IDLE, 00:00, magnetron_on=0, done=0 on the next edge.
